pulse_pattern_checker: RTL
==========================

# pulse_pattern_checker

Receive-side checker for the two-channel active-low pulse pattern (f, g) from our pattern generator. It samples both lines and measures the frame period, each channel's low width and the g-rise to f-fall gap. It compares every measurement against nominal values within a tolerance and reports per-frame results, error flags and a lock indication. It sits on the board-test path next to the generator, on the same clock.

## Interface
- PERIOD, 4601: nominal cycles between consecutive g falling edges
- G_LOW, 599: nominal g low width in cycles
- GAP, 51: nominal cycles from g rising edge to f falling edge
- F_LOW, 299: nominal f low width in cycles
- TOL, 2: allowed ± deviation on every measurement
- LOCK_FRAMES, 2: consecutive clean frames required for lock
- CW, 13: measurement counter width
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- f  in  1  monitored channel f, synchronous to clk, active low
- g  in  1  monitored channel g (frame reference), synchronous to clk, active low
- meas_valid  out  1  one-cycle strobe: frame measurement complete
- period_q  out  CW  measured period
- g_width_q  out  CW  measured g low width
- f_width_q  out  CW  measured f low width
- gap_q  out  CW  measured g-rise to f-fall gap
- err_period, err_g, err_f, err_gap  out  1 each  out-of-tolerance flags, valid with meas_valid
- err_order  out  1  f fell while g was low in this frame, valid with meas_valid
- timeout  out  1  one-cycle strobe: no g fall within PERIOD+TOL cycles
- locked  out  1  LOCK_FRAMES consecutive clean frames seen

## Operation
- Each input is registered once (s1), then again (s2). A fall is s2 & ~s1; a rise is ~s2 & s1.
- FSM states:
  - IDLE: wait for g fall, then go to G_LOW.
  - G_LOW: wait for g rise, then go to GAP.
  - GAP: wait for f fall, then go to F_LOW.
  - F_LOW: wait for f rise, then go to TAIL.
  - TAIL: wait for g fall.
- A g fall in any state other than IDLE closes the current frame and opens the next frame in the same cycle.
- A g fall in G_LOW, GAP or F_LOW is a short frame:
  - Measurements not yet taken report 0.
  - The corresponding err_* flags are set.
- Counters:
  - The period counter clears to 1 on g fall and increments every cycle.
  - The width counters count the cycles their channel's s1 is low.
  - The gap counter counts GAP-state cycles.
  - All counters saturate at 2^CW−1.
- An f fall while in G_LOW sets err_order. The FSM does not change state on it.
- Error rule: err_x = |meas − nominal| > TOL, computed with unsigned CW-bit compare. No wrap is allowed.
- Timeout: if the period counter reaches PERIOD+TOL+1 in any non-IDLE state:
  - pulse timeout;
  - clear locked;
  - go to IDLE;
  - meas_valid is not asserted.
- Lock: a clean-frame counter increments on a meas_valid with no err_* flags set. Any error or timeout clears both the counter and locked. locked=1 once the counter reaches LOCK_FRAMES.
- Simultaneous f fall and g rise in G_LOW: take G_LOW→GAP with gap_q=0. err_order is not set.
- Reset values: all outputs 0, FSM in IDLE, counters 0, s1/s2 = 1 (idle-high).

## Timing
- An input change lands in s1 at edge N. Edge detection is combinational in the cycle after N.
- meas_valid, the *_q values and the err flags are registered at edge N+1. meas_valid is high for exactly one cycle.
- The *_q values hold until the next meas_valid. The err flags are valid only while meas_valid is high.
- The timeout strobe is registered one cycle after the threshold count is reached.
- A reset asserted mid-frame discards the frame; no meas_valid is produced. After reset is released, the first meas_valid requires two g falls.

## Structure
- pulse_pattern_pkg holds:
  - the state enum (IDLE, G_LOW, GAP, F_LOW, TAIL);
  - default nominal constants;
  - a tolerance-compare function.
- Sub-module edge_sync, instantiated for f and for g: input register, delay register, rise/fall outputs, reset to 1.

## Test plan
- Nominal generator waveform (period 4601, g low 599, gap 51, f low 299), three frames → each meas_valid reports 4601/599/299/51 with no errors; locked rises at the second meas_valid.
- g low width 601, then 602 → no error for 601; err_g=1 and locked cleared for 602.
- f pulse omitted for one frame → meas_valid with f_width_q=0, err_f=1 and err_gap=1.
- g held high after one fall → timeout 4604 cycles after the fall; FSM in IDLE; locked=0.
- f driven low during g low → err_order=1 on that frame's meas_valid.
- reset pulsed at cycle 2000 of a frame → all outputs 0 the next cycle; next meas_valid only after two further g falls.

Source files
------------

// File: rtl/pulse_pattern_pkg.sv
// Shared types, nominal pattern constants and measurement helpers for the
// pulse pattern checker.
package pulse_pattern_pkg;

  // Nominal generator pattern and checker defaults
  localparam int unsigned PERIOD_DEF      = 32'd4601;
  localparam int unsigned G_LOW_DEF       = 32'd599;
  localparam int unsigned GAP_DEF         = 32'd51;
  localparam int unsigned F_LOW_DEF       = 32'd299;
  localparam int unsigned TOL_DEF         = 32'd2;
  localparam int unsigned LOCK_FRAMES_DEF = 32'd2;
  localparam int unsigned CW_DEF          = 32'd13;

  // Frame tracking states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_G_LOW = 3'd1,
    ST_GAP   = 3'd2,
    ST_F_LOW = 3'd3,
    ST_TAIL  = 3'd4
  } state_e;

  // True when |meas - nom| > tol; the subtraction is ordered so it never wraps
  function automatic logic tol_err(
    input logic [CW_DEF-1:0] meas,
    input logic [CW_DEF-1:0] nom,
    input logic [CW_DEF-1:0] tol
  );
    logic [CW_DEF-1:0] diff;
    if (meas >= nom) begin
      diff = meas - nom;
    end else begin
      diff = nom - meas;
    end
    return (diff > tol);
  endfunction

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CW_DEF-1:0] sat_inc(input logic [CW_DEF-1:0] v);
    if (v == {CW_DEF{1'b1}}) begin
      return v;
    end else begin
      return v + CW_DEF'(1);
    end
  endfunction

endpackage

// File: rtl/pulse_pattern_checker_edge_sync.sv
// Two-register input capture with rise/fall detection. Both stages reset to 1
// so an idle-high line produces no spurious edge after reset.
module edge_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_s1,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;

  // Capture the line (s1) and keep one cycle of history (s2)
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_s1   = r_s1;
  assign o_fall = r_s2 & ~r_s1;
  assign o_rise = ~r_s2 & r_s1;

endmodule

// File: rtl/pulse_pattern_checker.sv
// Receive-side checker for the active-low (f, g) pulse pattern: measures the
// frame period, both low widths and the g-rise to f-fall gap, flags values
// outside tolerance, detects missing frames and tracks lock.
module pulse_pattern_checker
  import pulse_pattern_pkg::*;
#(
  parameter int unsigned PERIOD      = PERIOD_DEF,
  parameter int unsigned G_LOW       = G_LOW_DEF,
  parameter int unsigned GAP         = GAP_DEF,
  parameter int unsigned F_LOW       = F_LOW_DEF,
  parameter int unsigned TOL         = TOL_DEF,
  parameter int unsigned LOCK_FRAMES = LOCK_FRAMES_DEF,
  parameter int unsigned CW          = CW_DEF
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_f,
  input  logic          i_g,
  output logic          o_meas_valid,
  output logic [CW-1:0] o_period_q,
  output logic [CW-1:0] o_g_width_q,
  output logic [CW-1:0] o_f_width_q,
  output logic [CW-1:0] o_gap_q,
  output logic          o_err_period,
  output logic          o_err_g,
  output logic          o_err_f,
  output logic          o_err_gap,
  output logic          o_err_order,
  output logic          o_timeout,
  output logic          o_locked
);

  localparam int unsigned LW = $clog2(LOCK_FRAMES + 1);

  localparam logic [CW-1:0] P_PERIOD  = CW'(PERIOD);
  localparam logic [CW-1:0] P_G_LOW   = CW'(G_LOW);
  localparam logic [CW-1:0] P_GAP     = CW'(GAP);
  localparam logic [CW-1:0] P_F_LOW   = CW'(F_LOW);
  localparam logic [CW-1:0] P_TOL     = CW'(TOL);
  localparam logic [CW-1:0] P_TIMEOUT = CW'(PERIOD + TOL + 1);
  localparam logic [LW-1:0] P_LOCK    = LW'(LOCK_FRAMES);
  localparam logic [LW-1:0] P_LOCK_M1 = LW'(LOCK_FRAMES - 1);

  // Synchronised channel views
  logic w_f_s1, w_f_rise, w_f_fall;
  logic w_g_s1, w_g_rise, w_g_fall;

  // Frame tracking
  state_e r_state;
  state_e w_state_nxt;

  // Free-running measurement counters
  logic [CW-1:0] r_period_cnt;
  logic [CW-1:0] r_gw_cnt;
  logic [CW-1:0] r_fw_cnt;
  logic [CW-1:0] r_gap_cnt;

  // Values captured during the current frame (0 until taken)
  logic [CW-1:0] r_gw_meas;
  logic [CW-1:0] r_fw_meas;
  logic [CW-1:0] r_gap_meas;
  logic          r_order_err;

  // Per-cycle control strobes
  logic w_timeout_hit;
  logic w_close;
  logic w_cap_g;
  logic w_cap_gap;
  logic w_cap_f;
  logic w_order_evt;

  // Tolerance results for the frame being closed
  logic w_err_period;
  logic w_err_g;
  logic w_err_f;
  logic w_err_gap;
  logic w_err_any;

  // Lock tracking
  logic [LW-1:0] r_clean_cnt;

  edge_sync u_sync_f (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_f),
    .o_s1    (w_f_s1),
    .o_rise  (w_f_rise),
    .o_fall  (w_f_fall)
  );

  edge_sync u_sync_g (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_g),
    .o_s1    (w_g_s1),
    .o_rise  (w_g_rise),
    .o_fall  (w_g_fall)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and capture strobes; timeout wins over everything, then a g
  // fall closes the running frame and opens the next one in the same cycle
  always_comb begin
    w_state_nxt   = r_state;
    w_timeout_hit = 1'b0;
    w_close       = 1'b0;
    w_cap_g       = 1'b0;
    w_cap_gap     = 1'b0;
    w_cap_f       = 1'b0;
    w_order_evt   = 1'b0;
    if ((r_state != ST_IDLE) && (r_period_cnt >= P_TIMEOUT)) begin
      w_timeout_hit = 1'b1;
      w_state_nxt   = ST_IDLE;
    end else if (w_g_fall) begin
      w_close     = (r_state != ST_IDLE);
      w_state_nxt = ST_G_LOW;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_IDLE;
        end
        ST_G_LOW: begin
          if (w_g_rise) begin
            // An f fall in this same cycle leaves the gap unmeasured (0)
            // and is not treated as an ordering error
            w_cap_g     = 1'b1;
            w_state_nxt = ST_GAP;
          end else if (w_f_fall) begin
            w_order_evt = 1'b1;
            w_state_nxt = ST_G_LOW;
          end else begin
            w_state_nxt = ST_G_LOW;
          end
        end
        ST_GAP: begin
          if (w_f_fall) begin
            w_cap_gap   = 1'b1;
            w_state_nxt = ST_F_LOW;
          end else begin
            w_state_nxt = ST_GAP;
          end
        end
        ST_F_LOW: begin
          if (w_f_rise) begin
            w_cap_f     = 1'b1;
            w_state_nxt = ST_TAIL;
          end else begin
            w_state_nxt = ST_F_LOW;
          end
        end
        ST_TAIL: begin
          w_state_nxt = ST_TAIL;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Measurement counters: period restarts at 1 on g fall, widths count s1-low
  // cycles, gap counts cycles spent in GAP; all saturate
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_period_cnt <= '0;
      r_gw_cnt     <= '0;
      r_fw_cnt     <= '0;
      r_gap_cnt    <= '0;
    end else begin
      if (w_g_fall) begin
        r_period_cnt <= CW'(1);
        r_gw_cnt     <= CW'(1);
      end else begin
        r_period_cnt <= sat_inc(r_period_cnt);
        if (!w_g_s1) begin
          r_gw_cnt <= sat_inc(r_gw_cnt);
        end
      end
      if (w_f_fall) begin
        r_fw_cnt <= CW'(1);
      end else if (!w_f_s1) begin
        r_fw_cnt <= sat_inc(r_fw_cnt);
      end
      if (w_cap_g) begin
        r_gap_cnt <= CW'(1);
      end else if (r_state == ST_GAP) begin
        r_gap_cnt <= sat_inc(r_gap_cnt);
      end
    end
  end

  // Per-frame captured values, cleared whenever a new frame opens
  always_ff @(posedge i_clk) begin
    if (i_reset || w_g_fall) begin
      r_gw_meas   <= '0;
      r_fw_meas   <= '0;
      r_gap_meas  <= '0;
      r_order_err <= 1'b0;
    end else begin
      if (w_cap_g) begin
        r_gw_meas <= r_gw_cnt;
      end
      if (w_cap_gap) begin
        r_gap_meas <= r_gap_cnt;
      end
      if (w_cap_f) begin
        r_fw_meas <= r_fw_cnt;
      end
      if (w_order_evt) begin
        r_order_err <= 1'b1;
      end
    end
  end

  assign w_err_period = tol_err(r_period_cnt, P_PERIOD, P_TOL);
  assign w_err_g      = tol_err(r_gw_meas, P_G_LOW, P_TOL);
  assign w_err_f      = tol_err(r_fw_meas, P_F_LOW, P_TOL);
  assign w_err_gap    = tol_err(r_gap_meas, P_GAP, P_TOL);
  assign w_err_any    = w_err_period | w_err_g | w_err_f | w_err_gap | r_order_err;

  // Result registers: values hold between frames, flags only with the strobe
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_meas_valid <= 1'b0;
      o_timeout    <= 1'b0;
      o_period_q   <= '0;
      o_g_width_q  <= '0;
      o_f_width_q  <= '0;
      o_gap_q      <= '0;
      o_err_period <= 1'b0;
      o_err_g      <= 1'b0;
      o_err_f      <= 1'b0;
      o_err_gap    <= 1'b0;
      o_err_order  <= 1'b0;
    end else begin
      o_meas_valid <= w_close;
      o_timeout    <= w_timeout_hit;
      if (w_close) begin
        o_period_q   <= r_period_cnt;
        o_g_width_q  <= r_gw_meas;
        o_f_width_q  <= r_fw_meas;
        o_gap_q      <= r_gap_meas;
        o_err_period <= w_err_period;
        o_err_g      <= w_err_g;
        o_err_f      <= w_err_f;
        o_err_gap    <= w_err_gap;
        o_err_order  <= r_order_err;
      end else begin
        o_err_period <= 1'b0;
        o_err_g      <= 1'b0;
        o_err_f      <= 1'b0;
        o_err_gap    <= 1'b0;
        o_err_order  <= 1'b0;
      end
    end
  end

  // Clean-frame run length and lock; any error or timeout restarts the run
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_clean_cnt <= '0;
      o_locked    <= 1'b0;
    end else if (w_timeout_hit) begin
      r_clean_cnt <= '0;
      o_locked    <= 1'b0;
    end else if (w_close) begin
      if (w_err_any) begin
        r_clean_cnt <= '0;
        o_locked    <= 1'b0;
      end else if (r_clean_cnt >= P_LOCK_M1) begin
        r_clean_cnt <= P_LOCK;
        o_locked    <= 1'b1;
      end else begin
        r_clean_cnt <= r_clean_cnt + LW'(1);
      end
    end
  end

endmodule
